// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Operands load on start; results are registered and held until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  logic             d_bit_s;
  logic             br_next_s;
  logic             load_s;

  // Full-subtractor slice on the current LSBs and the running borrow.
  assign d_bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next_s = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign load_s    = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    br_d         = br_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (load_s) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit_s, res_q[WIDTH-1:1]};
        br_d   = br_next_s;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d      = DONE;
          done_d       = 1'b1;
          diff_d       = {d_bit_s, res_q[WIDTH-1:1]};
          borrow_out_d = br_next_s;
          // Final d is the result MSB; operand MSBs were captured at load time.
          overflow_d   = (a_msb_q != b_msb_q) && (d_bit_s != a_msb_q);
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      a_sh_d  = a;
      b_sh_d  = b;
      br_d    = borrow_in;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
      res_d   = '0;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      br_q         <= br_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases plus random operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain-integer reference: unsigned borrow and signed-range overflow.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int r;
    int sx;
    int sy;
    int s;
    r  = int'(x) - int'(y) - int'(c);
    d  = W'(r);
    bo = (r < 0);
    sx = $signed(x);
    sy = $signed(y);
    s  = sx - sy - int'(c);
    ov = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    a = ta;
    b = tb_v;
    borrow_in = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called one cycle after start was accepted; walks RUN, checks DONE and optionally chains.
  task automatic finish_op(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec,
                           input bit noise, input bit chain,
                           input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    logic [W-1:0] ed;
    logic         ebo;
    logic         eov;
    model(ea, eb, ec, ed, ebo, eov);
    for (int i = 0; i < W; i++) begin
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      check("diff_hold", diff, last_diff);
      if (noise && i >= 2 && i <= 4) begin
        a = (i == 2) ? 8'hFF : W'($urandom);
        b = W'($urandom);
        borrow_in = 1'($urandom);
        start = (i == 2);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("diff", diff, ed);
    check("borrow_out", borrow_out, ebo);
    check("overflow", overflow, eov);
    last_diff = ed;
    if (chain) begin
      issue(na, nb, nc);
    end else begin
      tick();
      check("done_clear", done, 1'b0);
      check("diff_after", diff, ed);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_bo", borrow_out, 1'b0);
    check("rst_ov", overflow, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();

    issue(8'h05, 8'h03, 1'b0); finish_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    issue(8'h03, 8'h05, 1'b0); finish_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    issue(8'h00, 8'h00, 1'b1); finish_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    issue(8'h80, 8'h01, 1'b0); finish_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    issue(8'h10, 8'h01, 1'b0); finish_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Back-to-back: new start in the DONE cycle.
    issue(8'h05, 8'h03, 1'b0);
    finish_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b1, 8'h7F, 8'hFF, 1'b0);
    finish_op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Reset in the middle of RUN.
    issue(8'h55, 8'h22, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_bo", borrow_out, 1'b0);
    tick();
    rst_n = 1'b1;
    last_diff = '0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      check("abort_nodone", done, 1'b0);
    end
    issue(8'hA5, 8'h5A, 1'b1); finish_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc);
      finish_op(ra, rb, rc, bit'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
